aoc5_range_coalescer: RTL and testbench
=======================================

# aoc5_range_coalescer

Downstream stage of the 16-wide bitonic sorter in the AoC day-5 pipeline. Accepts one sorted batch of 16 `tuple_pair_t` ranges per `valid_in` pulse and buffers up to two batches. Walks each batch in ascending order, merging overlapping or adjacent ranges. Emits the coalesced ranges one per beat on a valid/ready stream.

## Interface
Parameters:
- `DEPTH`, default 2: batch buffer slots; legal values are 1 or 2.
- `TOTAL_W`, default 64: width of the coverage accumulator.

Ports:
- `clock`: in, 1. Single clock; all state changes on the rising edge.
- `reset`: in, 1. Synchronous, active-high.
- `valid_in`: in, 1. A sorted batch is present on `pairs_in_flat`. Single-cycle pulse; there is no upstream ready.
- `pairs_in_flat`: in, `ARR_16_FLAT_WIDTH`. 16 ranges, index 0 lowest, sorted by range low bound.
- `full_out`: in/out direction is out, 1. Buffer holds `DEPTH` batches.
- `valid_out`: out, 1. `pair_out` holds a coalesced range.
- `ready_in`: in, 1. Downstream accepts the beat when `valid_out && ready_in`.
- `pair_out`: out, `$bits(tuple_pair_t)`. Coalesced range {lo, hi}.
- `last_out`: out, 1. Marks the final beat of a batch.
- `overflow_out`: out, 1. Sticky; set when a batch is dropped.
- `total_out`: out, `TOTAL_W`. Only present with `AOC5_TOTAL_EN`.

## Operation
- The range low bound is the `tuple_pair_t` first member, the high bound the second. Both are unsigned and inclusive.
- **Buffer:** `DEPTH`-slot FIFO of whole batches, with a write pointer, a read pointer and a count.
  - `valid_in` with count < `DEPTH`: batch written and count incremented.
  - `valid_in` with count == `DEPTH`: batch dropped and `overflow_out` set. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count is unchanged.
- **Walker FSM**, states IDLE, WALK, FLUSH:
  - IDLE: if count > 0, go to WALK with idx=0 and `cur_v`=0.
  - WALK: examine element e = head[idx].
    - Padding (lo > hi): skip and advance.
    - `cur_v`=0: cur=e, `cur_v`=1, advance.
    - e.lo <= cur.hi+1: merge with cur.hi = max(cur.hi, e.hi), then advance. The compare is done at width+1, so a cur.hi equal to all-ones does not wrap.
    - Otherwise emit: load cur into the output register, set cur=e, advance.
    - After idx 15 has advanced, go to FLUSH.
  - FLUSH:
    - If `cur_v`, emit cur with `last_out`=1.
    - Pop the head slot and go to IDLE.
    - A batch that is all padding pops with no beats emitted.
- **Emit rule:** allowed only when `!valid_out || ready_in`. Otherwise the walker holds its state, idx and cur until the emit is allowed.
- **Output register:** `pair_out`, `last_out` and `valid_out` are held stable while `valid_out && !ready_in`.
- **Reset mid-operation:** the FIFO is emptied, the FSM returns to IDLE, and the in-flight batch and any pending beat are discarded.

## Timing
- Reset values:
  - `valid_out`=0, `last_out`=0, `pair_out`=0.
  - `full_out`=0, `overflow_out`=0, `total_out`=0.
  - FSM in IDLE, count=0.
- With accept at edge E0, no backpressure and disjoint ranges:
  - WALK is entered at E1.
  - Element i is processed at E2+i.
  - First beat is visible after E3.
  - Last beat is visible after E18, at which point the FSM is back in IDLE.
  - The next buffered batch enters WALK at E19.
- Minimum cost is 18 cycles per batch plus stall cycles.
- `full_out` is registered and reflects count after each edge.

## Configuration
- `AOC5_TOTAL_EN` defined:
  - `total_out` port exists.
  - On each accepted beat (`valid_out && ready_in`), `total_out += hi - lo + 1`, computed at `TOTAL_W` and wrapping modulo 2^`TOTAL_W`.
  - Cleared only by reset.
- `AOC5_TOTAL_EN` undefined: the port and the accumulator are absent; all other behaviour is identical.

## Test plan
- **Disjoint:** batch with lo=10i, hi=10i+3 for i=0..15, `ready_in`=1.
  - 16 beats in order, `last_out` only on {150,153}.
  - First beat 3 cycles after accept.
  - `total_out`=64.
- **Chain merge:** lo=i, hi=i+1 for i=0..15.
  - Single beat {0,16} with `last_out`=1.
  - `total_out`=17.
- **Padding:** 8 ranges {100i,100i+5} for i=0..7 plus 8 entries {MAX,0}.
  - 8 beats, last on {700,705}, `total_out`=48.
  - Batch of 16 padding entries: no beats, FIFO empties.
- **Backpressure:** `ready_in`=0 for 10 cycles after the first `valid_out`.
  - `pair_out` stable at {0,3}, walker frozen.
  - On release, all 16 beats arrive with no loss or duplication.
- **Overflow:** 3 `valid_in` pulses 1 cycle apart with `ready_in`=0.
  - `full_out`=1 after the second pulse.
  - Third batch dropped and `overflow_out`=1 (sticky).
  - Batches 1 and 2 later drain intact.
- **Reset mid-walk:** assert `reset` 6 cycles after accept.
  - Next cycle: all outputs at their reset values, count=0.
  - A fresh batch afterwards produces the correct beats.

Source files
------------

// File: rtl/aoc5_range_coalescer.sv
// Range coalescer: buffers whole sorted 16-range batches and walks each one,
// merging overlapping/adjacent ranges into a valid/ready beat stream.
// Optional coverage accumulator on total_out is enabled by AOC5_TOTAL_EN.
package aoc5_pkg;
  localparam int VAL_W = 64;
  typedef struct packed {
    logic [VAL_W-1:0] lo;
    logic [VAL_W-1:0] hi;
  } tuple_pair_t;
  localparam int PAIR_W            = $bits(tuple_pair_t);
  localparam int ARR_16_FLAT_WIDTH = 16 * PAIR_W;
endpackage

module aoc5_range_coalescer
  import aoc5_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TOTAL_W = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [ARR_16_FLAT_WIDTH-1:0] pairs_in_flat,
  output logic                         full_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output tuple_pair_t                  pair_out,
  output logic                         last_out,
  output logic                         overflow_out
`ifdef AOC5_TOTAL_EN
  ,
  output logic [TOTAL_W-1:0]           total_out
`endif
);

  typedef enum logic [1:0] {IDLE, WALK, FLUSH} state_t;

  logic [ARR_16_FLAT_WIDTH-1:0] mem [DEPTH];
  logic                         wr_ptr, rd_ptr;
  logic [1:0]                   count, count_nx;
  logic                         push, pop;

  state_t      state, state_nx;
  logic [3:0]  idx;
  tuple_pair_t cur, e;
  logic        cur_v;
  tuple_pair_t head [16];
  logic        pad, merge, can_emit, emit, fire, adv;

  for (genvar g = 0; g < 16; g++) begin : g_unpack
    assign head[g] = tuple_pair_t'(mem[rd_ptr][g*PAIR_W +: PAIR_W]);
  end

  // Batch FIFO; a full buffer drops the incoming batch even if a pop coincides.
  assign push     = valid_in && (count < 2'(DEPTH));
  assign count_nx = count + 2'(push) - 2'(pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= pairs_in_flat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      full_out     <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == 1'(DEPTH-1)) ? 1'b0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == 1'(DEPTH-1)) ? 1'b0 : rd_ptr + 1'b1;
      if (valid_in && !push) overflow_out <= 1'b1;
      count    <= count_nx;
      full_out <= (count_nx == 2'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != 2'd0)        state_nx = WALK;
      WALK:    if (adv && idx == 4'd15)  state_nx = FLUSH;
      FLUSH:   if (pop)                  state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Merge compare at VAL_W+1 so an all-ones cur.hi does not wrap to 0.
  always_comb begin
    e        = head[idx];
    pad      = e.lo > e.hi;
    merge    = {1'b0, e.lo} <= ({1'b0, cur.hi} + (VAL_W+1)'(1));
    can_emit = !valid_out || ready_in;
    emit     = 1'b0;
    adv      = 1'b0;
    pop      = 1'b0;
    case (state)
      WALK: begin
        emit = !pad && cur_v && !merge;
        adv  = !emit || can_emit;
      end
      FLUSH: begin
        emit = cur_v;
        pop  = !emit || can_emit;
      end
      default: ;
    endcase
    fire = emit && can_emit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx   <= '0;
      cur   <= '0;
      cur_v <= 1'b0;
    end else begin
      case (state)
        IDLE: if (count != 2'd0) begin
          idx   <= '0;
          cur_v <= 1'b0;
        end
        WALK: if (adv) begin
          idx <= idx + 4'd1;
          if (!pad) begin
            if (cur_v && merge) begin
              if (e.hi > cur.hi) cur.hi <= e.hi;
            end else begin
              cur   <= e;
              cur_v <= 1'b1;
            end
          end
        end
        FLUSH: if (pop) cur_v <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      pair_out  <= '0;
    end else if (fire) begin
      valid_out <= 1'b1;
      last_out  <= (state == FLUSH);
      pair_out  <= cur;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

`ifdef AOC5_TOTAL_EN
  always_ff @(posedge clock) begin
    if (reset) total_out <= '0;
    else if (valid_out && ready_in)
      total_out <= total_out + TOTAL_W'(pair_out.hi) - TOTAL_W'(pair_out.lo) + TOTAL_W'(1);
  end
`endif

endmodule

// File: tb/tb_aoc5_range_coalescer.sv
// Directed bench for aoc5_range_coalescer: disjoint, chain merge, padding,
// backpressure, overflow and mid-walk reset scenarios.
module tb_aoc5_range_coalescer;
  import aoc5_pkg::*;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic                         valid_in = 1'b0;
  logic [ARR_16_FLAT_WIDTH-1:0] pairs_in_flat = '0;
  logic                         full_out, valid_out, last_out, overflow_out;
  logic                         ready_in = 1'b1;
  tuple_pair_t                  pair_out;
`ifdef AOC5_TOTAL_EN
  logic [63:0]                  total_out;
`endif

  aoc5_range_coalescer dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pairs_in_flat(pairs_in_flat),
    .full_out(full_out), .valid_out(valid_out), .ready_in(ready_in),
    .pair_out(pair_out), .last_out(last_out), .overflow_out(overflow_out)
`ifdef AOC5_TOTAL_EN
    , .total_out(total_out)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  logic [ARR_16_FLAT_WIDTH-1:0] batch;
  logic [128:0] beats [$];
  logic [128:0] want  [$];
  localparam logic [63:0] MAX = '1;

  always @(posedge clock)
    if (!reset && valid_out && ready_in) beats.push_back({pair_out, last_out});

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pair(input int i, input logic [63:0] lo, input logic [63:0] hi);
    batch[i*PAIR_W +: PAIR_W] = {lo, hi};
  endtask

  task automatic send();
    @(negedge clock);
    pairs_in_flat = batch;
    valid_in = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    beats.delete();
    want.delete();
  endtask

  task automatic compare_beats(input string tag);
    chk({tag, "_nbeats"}, 256'(beats.size()), 256'(want.size()));
    for (int i = 0; i < want.size() && i < beats.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 256'(beats[i]), 256'(want[i]));
  endtask

  task automatic mk_disjoint();
    for (int i = 0; i < 16; i++) set_pair(i, 64'(10*i), 64'(10*i+3));
  endtask
  task automatic want_disjoint();
    for (int i = 0; i < 16; i++) want.push_back({64'(10*i), 64'(10*i+3), i == 15});
  endtask
  task automatic mk_chain();
    for (int i = 0; i < 16; i++) set_pair(i, 64'(i), 64'(i+1));
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 256'(valid_out), 0);
    chk("rst_last", 256'(last_out), 0);
    chk("rst_pair", 256'(pair_out), 0);
    chk("rst_full", 256'(full_out), 0);
    chk("rst_ovf", 256'(overflow_out), 0);
    chk("rst_count", 256'(dut.count), 0);
    chk("rst_state", 256'(dut.state), 0);
`ifdef AOC5_TOTAL_EN
    chk("rst_total", 256'(total_out), 0);
`endif

    // Disjoint batch with latency checks
    ready_in = 1'b1;
    mk_disjoint();
    send();
    repeat (2) @(negedge clock);
    chk("dis_lat_e2", 256'(valid_out), 0);
    @(negedge clock);
    chk("dis_lat_e3", 256'(valid_out), 1);
    chk("dis_first", 256'(pair_out), {64'd0, 64'd3});
    repeat (15) @(negedge clock);
    chk("dis_last_e18", 256'({pair_out, last_out}), {64'd150, 64'd153, 1'b1});
    chk("dis_idle_e18", 256'(dut.state), 0);
    repeat (10) @(negedge clock);
    want_disjoint();
    compare_beats("dis");
    chk("dis_count", 256'(dut.count), 0);
`ifdef AOC5_TOTAL_EN
    chk("dis_total", 256'(total_out), 64);
`endif

    // Chain merge
    do_reset();
    mk_chain();
    send();
    repeat (30) @(negedge clock);
    want.push_back({64'd0, 64'd16, 1'b1});
    compare_beats("chain");
`ifdef AOC5_TOTAL_EN
    chk("chain_total", 256'(total_out), 17);
`endif

    // Half padding, then all padding
    do_reset();
    for (int i = 0; i < 16; i++)
      if (i < 8) set_pair(i, 64'(100*i), 64'(100*i+5)); else set_pair(i, MAX, 64'd0);
    send();
    repeat (30) @(negedge clock);
    for (int i = 0; i < 8; i++) want.push_back({64'(100*i), 64'(100*i+5), i == 7});
    compare_beats("pad");
`ifdef AOC5_TOTAL_EN
    chk("pad_total", 256'(total_out), 48);
`endif
    beats.delete();
    for (int i = 0; i < 16; i++) set_pair(i, MAX, 64'd0);
    send();
    repeat (30) @(negedge clock);
    chk("allpad_nbeats", 256'(beats.size()), 0);
    chk("allpad_count", 256'(dut.count), 0);
    chk("allpad_state", 256'(dut.state), 0);

    // Backpressure
    do_reset();
    ready_in = 1'b0;
    mk_disjoint();
    send();
    for (int i = 0; i < 10 && !valid_out; i++) @(negedge clock);
    chk("bp_valid_seen", 256'(valid_out), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("bp_hold%0d", i), 256'({valid_out, pair_out, last_out}), {1'b1, 64'd0, 64'd3, 1'b0});
      chk($sformatf("bp_idx%0d", i), 256'(dut.idx), 2);
    end
    ready_in = 1'b1;
    repeat (40) @(negedge clock);
    want_disjoint();
    compare_beats("bp");

    // Overflow: third batch dropped while two are buffered
    do_reset();
    ready_in = 1'b0;
    mk_disjoint();
    send();
    mk_chain();
    send();
    chk("ovf_full", 256'(full_out), 1);
    chk("ovf_pre", 256'(overflow_out), 0);
    for (int i = 0; i < 16; i++) set_pair(i, 64'(1000+10*i), 64'(1000+10*i+1));
    send();
    chk("ovf_set", 256'(overflow_out), 1);
    repeat (3) @(negedge clock);
    ready_in = 1'b1;
    repeat (70) @(negedge clock);
    want_disjoint();
    want.push_back({64'd0, 64'd16, 1'b1});
    compare_beats("ovf");
    chk("ovf_sticky", 256'(overflow_out), 1);
    chk("ovf_drained", 256'({full_out, dut.count}), 0);

    // Reset mid-walk
    do_reset();
    mk_disjoint();
    send();
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_outs", 256'({valid_out, last_out, pair_out, full_out, overflow_out}), 0);
    chk("mid_rst_count", 256'(dut.count), 0);
    chk("mid_rst_state", 256'(dut.state), 0);
`ifdef AOC5_TOTAL_EN
    chk("mid_rst_total", 256'(total_out), 0);
`endif
    reset = 1'b0;
    beats.delete();
    want.delete();
    mk_chain();
    send();
    repeat (30) @(negedge clock);
    want.push_back({64'd0, 64'd16, 1'b1});
    compare_beats("post_rst");
`ifdef AOC5_TOTAL_EN
    chk("post_rst_total", 256'(total_out), 17);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
